issue_sched: RTL and testbench

- Issue scheduler between the decode stage and the two execution pipes.
- Each cycle it picks NULL, SINGLE or DUAL issue for the two decoded slots.
- Tracks in-flight loads in a 32-entry register scoreboard.
- Runs the multi-cycle divider busy FSM and keeps issue performance counters.
- Pipe 0 is the complex pipe (mul/div/mem/cp0). Pipe 1 is the simple pipe.

---
 rtl/issue_sched_pkg.sv | 34 +++
 rtl/issue_scoreboard.sv | 60 ++++++
 rtl/issue_sched.sv | 147 ++++++++++++++
 tb/tb_issue_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/issue_sched_pkg.sv
// Shared types for the issue scheduler: slot-info layout, issue-mode encodings, divider FSM states.
// No logic beyond a small helper predicate.
package issue_sched_pkg;

    localparam int SLOT_INFO_WD = 21;

    localparam logic [1:0] ISSUE_NULL   = 2'd0;
    localparam logic [1:0] ISSUE_SINGLE = 2'd1;
    localparam logic [1:0] ISSUE_DUAL   = 2'd2;

    // Field order mirrors the decode bus, MSB first: [20:16] rs1 .. [0] uses_hilo
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] dest;
        logic       gr_we;
        logic       is_load;
        logic       is_br;
        logic       is_complex;
        logic       is_div;
        logic       uses_hilo;
    } slot_info_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    // A slot whose result arrives late and must block dependants until writeback
    function automatic logic makes_pending(input slot_info_t s);
        return s.is_load & s.gr_we & (s.dest != 5'd0);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-load register scoreboard: 32 bits, r0 never pending; four combinational lookups.
// Latency: reads see registered state; set/clear/flush take effect after the next clk edge.
// Backpressure: none; the caller only asserts set for slots that actually issue.
module issue_scoreboard
    import issue_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       set0_en,
    input  logic [4:0] set0_idx,
    input  logic       set1_en,
    input  logic [4:0] set1_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic       flush,
    input  logic [4:0] rd_idx0,
    input  logic [4:0] rd_idx1,
    input  logic [4:0] rd_idx2,
    input  logic [4:0] rd_idx3,
    output logic       pend0,
    output logic       pend1,
    output logic       pend2,
    output logic       pend3
);

    logic [31:0] pend_q;
    logic [31:0] pend_nxt;

    // Clear first so a same-cycle set of the same register wins; flush beats everything.
    always_comb begin
        pend_nxt = pend_q;
        if (clr_en) begin
            pend_nxt[clr_idx] = 1'b0;
        end
        if (set0_en) begin
            pend_nxt[set0_idx] = 1'b1;
        end
        if (set1_en) begin
            pend_nxt[set1_idx] = 1'b1;
        end
        if (flush) begin
            pend_nxt = '0;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    assign pend0 = pend_q[rd_idx0];
    assign pend1 = pend_q[rd_idx1];
    assign pend2 = pend_q[rd_idx2];
    assign pend3 = pend_q[rd_idx3];

endmodule

// File: rtl/issue_sched.sv
// Dual-issue scheduler: picks NULL/SINGLE/DUAL for two decoded slots, tracks loads and divider busy.
// Latency: zero-cycle issue decision from registered state; state updates on the next clk edge.
// Backpressure: issues nothing when issue_allowin is low or flush is high; decode holds its slots.
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int CNT_WD  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_allowin,
    input  logic                    slot0_valid,
    input  logic                    slot1_valid,
    input  logic [SLOT_INFO_WD-1:0] slot0_info,
    input  logic [SLOT_INFO_WD-1:0] slot1_info,
    input  logic                    load_wb_valid,
    input  logic [4:0]              load_wb_dest,
    input  logic                    flush,
    output logic [1:0]              issue_mode,
    output logic                    div_busy,
    output logic [CNT_WD-1:0]       perf_dual_cnt,
    output logic [CNT_WD-1:0]       perf_single_cnt,
    output logic [CNT_WD-1:0]       perf_stall_cnt
);

    localparam int DCW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    slot_info_t s0;
    slot_info_t s1;
    assign s0 = slot_info_t'(slot0_info);
    assign s1 = slot_info_t'(slot1_info);

    logic       s0_rs1_pend, s0_rs2_pend, s1_rs1_pend, s1_rs2_pend;
    logic       ok0, ok1;
    logic       raw_hz, waw_hz;
    logic       div_issue;
    div_state_t div_state, div_state_nxt;
    logic [DCW-1:0] div_cnt, div_cnt_nxt;

    issue_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .set0_en  (ok0 & makes_pending(s0)),
        .set0_idx (s0.dest),
        .set1_en  (ok1 & makes_pending(s1)),
        .set1_idx (s1.dest),
        .clr_en   (load_wb_valid),
        .clr_idx  (load_wb_dest),
        .flush    (flush),
        .rd_idx0  (s0.rs1),
        .rd_idx1  (s0.rs2),
        .rd_idx2  (s1.rs1),
        .rd_idx3  (s1.rs2),
        .pend0    (s0_rs1_pend),
        .pend1    (s0_rs2_pend),
        .pend2    (s1_rs1_pend),
        .pend3    (s1_rs2_pend)
    );

    assign div_busy = (div_state == DIV_BUSY);

    // Intra-pair hazards; only slot 1 can be hurt since slot 0 is older.
    assign raw_hz = s0.gr_we && (s0.dest != 5'd0) &&
                    ((s1.rs1 == s0.dest) || (s1.rs2 == s0.dest));
    assign waw_hz = s0.gr_we && s1.gr_we && (s0.dest != 5'd0) && (s0.dest == s1.dest);

    assign ok0 = slot0_valid && issue_allowin && !flush &&
                 !s0_rs1_pend && !s0_rs2_pend &&
                 !(s0.uses_hilo && div_busy) && !(s0.is_div && div_busy);

    // Branch in slot 0 is allowed; only slot 1 is barred from branches and pipe-0 work.
    assign ok1 = ok0 && slot1_valid &&
                 !s1_rs1_pend && !s1_rs2_pend &&
                 !(s1.uses_hilo && div_busy) && !(s1.is_div && div_busy) &&
                 !s1.is_complex && !s1.is_br && !raw_hz && !waw_hz;

    always_comb begin
        issue_mode = ISSUE_NULL;
        if (ok1) begin
            issue_mode = ISSUE_DUAL;
        end else if (ok0) begin
            issue_mode = ISSUE_SINGLE;
        end
    end

    assign div_issue = ok0 && s0.is_div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
        end else begin
            div_state <= div_state_nxt;
            div_cnt   <= div_cnt_nxt;
        end
    end

    // Counter loaded with DIV_LAT-1 and run down to 0 gives exactly DIV_LAT busy cycles.
    always_comb begin
        div_state_nxt = div_state;
        div_cnt_nxt   = div_cnt;
        if (flush) begin
            div_state_nxt = DIV_IDLE;
            div_cnt_nxt   = '0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (div_issue) begin
                        div_state_nxt = DIV_BUSY;
                        div_cnt_nxt   = DCW'(DIV_LAT - 1);
                    end
                end
                DIV_BUSY: begin
                    if (div_cnt == '0) begin
                        div_state_nxt = DIV_IDLE;
                    end else begin
                        div_cnt_nxt = div_cnt - 1'b1;
                    end
                end
                default: begin
                    div_state_nxt = DIV_IDLE;
                    div_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_dual_cnt   <= '0;
            perf_single_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (issue_mode == ISSUE_DUAL) begin
                perf_dual_cnt <= perf_dual_cnt + 1'b1;
            end
            if (issue_mode == ISSUE_SINGLE) begin
                perf_single_cnt <= perf_single_cnt + 1'b1;
            end
            if (slot0_valid && issue_allowin && !flush && (issue_mode == ISSUE_NULL)) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: each stimulus cycle queues its expected outputs,
// a negedge monitor pops and compares them.
module tb_issue_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_allowin = 1'b0;
    logic        slot0_valid = 1'b0;
    logic        slot1_valid = 1'b0;
    logic [20:0] slot0_info = '0;
    logic [20:0] slot1_info = '0;
    logic        load_wb_valid = 1'b0;
    logic [4:0]  load_wb_dest = '0;
    logic        flush = 1'b0;
    logic [1:0]  issue_mode;
    logic        div_busy;
    logic [31:0] perf_dual_cnt, perf_single_cnt, perf_stall_cnt;

    int vecs = 0;
    int miss = 0;
    int exp_dual = 0, exp_single = 0, exp_stall = 0;
    int cyc_id = 0;

    typedef struct {
        int         id;
        logic [1:0] mode;
        logic       busy;
        int         dual;
        int         single;
        int         stall;
    } exp_t;

    exp_t exp_q[$];

    issue_sched #(.DIV_LAT(4), .CNT_WD(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .issue_allowin   (issue_allowin),
        .slot0_valid     (slot0_valid),
        .slot1_valid     (slot1_valid),
        .slot0_info      (slot0_info),
        .slot1_info      (slot1_info),
        .load_wb_valid   (load_wb_valid),
        .load_wb_dest    (load_wb_dest),
        .flush           (flush),
        .issue_mode      (issue_mode),
        .div_busy        (div_busy),
        .perf_dual_cnt   (perf_dual_cnt),
        .perf_single_cnt (perf_single_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] mk(input int rs1, input int rs2, input int dest,
                                       input bit we, input bit ld, input bit br,
                                       input bit cx, input bit dv, input bit hl);
        return {rs1[4:0], rs2[4:0], dest[4:0], we, ld, br, cx, dv, hl};
    endfunction

    function automatic logic [20:0] alu(input int rs1, input int rs2, input int dest);
        return mk(rs1, rs2, dest, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One stimulus cycle: drive, queue expectation, advance the model, step to the next edge.
    task automatic cyc(input bit v0, input logic [20:0] i0, input bit v1, input logic [20:0] i1,
                       input bit allow, input bit wbv, input int wbd, input bit fl,
                       input logic [1:0] em, input bit eb);
        exp_t e;
        slot0_valid   = v0;
        slot0_info    = i0;
        slot1_valid   = v1;
        slot1_info    = i1;
        issue_allowin = allow;
        load_wb_valid = wbv;
        load_wb_dest  = wbd[4:0];
        flush         = fl;
        cyc_id++;
        e.id = cyc_id; e.mode = em; e.busy = eb;
        e.dual = exp_dual; e.single = exp_single; e.stall = exp_stall;
        exp_q.push_back(e);
        if (em == 2'd2) exp_dual++;
        if (em == 2'd1) exp_single++;
        if (v0 && allow && !fl && em == 2'd0) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("mode#%0d", e.id), {30'd0, issue_mode}, {30'd0, e.mode});
            check($sformatf("busy#%0d", e.id), {31'd0, div_busy}, {31'd0, e.busy});
            check($sformatf("dual#%0d", e.id), perf_dual_cnt, e.dual);
            check($sformatf("single#%0d", e.id), perf_single_cnt, e.single);
            check($sformatf("stall#%0d", e.id), perf_stall_cnt, e.stall);
        end
    end

    initial begin
        logic [20:0] z;
        logic [20:0] ld7, ld9, dv, mfhi;
        z    = '0;
        ld7  = mk(1, 2, 7, 1, 1, 0, 1, 0, 0);
        ld9  = mk(1, 2, 9, 1, 1, 0, 1, 0, 0);
        dv   = mk(1, 2, 0, 0, 0, 0, 1, 1, 0);
        mfhi = mk(0, 0, 13, 1, 0, 0, 1, 0, 1);

        #3;
        check("rst_mode", {30'd0, issue_mode}, 32'd0);
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_cnt", perf_dual_cnt | perf_single_cnt | perf_stall_cnt, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // pairing rules
        cyc(1, alu(1, 2, 3),  1, alu(4, 0, 6),  1, 0, 0, 0, 2'd2, 0);
        cyc(1, alu(1, 2, 5),  1, alu(0, 5, 8),  1, 0, 0, 0, 2'd1, 0);
        cyc(1, alu(1, 2, 10), 1, alu(1, 2, 10), 1, 0, 0, 0, 2'd1, 0);
        cyc(1, alu(1, 2, 3),  1, mk(4, 0, 6, 1, 0, 0, 1, 0, 0), 1, 0, 0, 0, 2'd1, 0);
        cyc(1, mk(1, 2, 0, 0, 0, 1, 0, 0, 0), 1, alu(3, 4, 11), 1, 0, 0, 0, 2'd2, 0);
        cyc(1, alu(1, 2, 3),  1, mk(3, 0, 0, 0, 0, 1, 0, 0, 0), 1, 0, 0, 0, 2'd1, 0);
        // load-use, same-cycle writeback still stalls
        cyc(1, ld7,           0, z, 1, 0, 0, 0, 2'd1, 0);
        cyc(1, alu(7, 0, 12), 0, z, 1, 0, 0, 0, 2'd0, 0);
        cyc(1, alu(7, 0, 12), 0, z, 1, 1, 7, 0, 2'd0, 0);
        cyc(1, alu(7, 0, 12), 0, z, 1, 0, 0, 0, 2'd1, 0);
        // no issue without slot0 or without allowin, and no stall counted
        cyc(0, z,             1, alu(1, 2, 3), 1, 0, 0, 0, 2'd0, 0);
        cyc(1, alu(1, 2, 3),  0, z, 0, 0, 0, 0, 2'd0, 0);
        // set beats same-cycle clear
        cyc(1, ld9,           0, z, 1, 1, 9, 0, 2'd1, 0);
        cyc(1, alu(0, 9, 12), 0, z, 1, 0, 0, 0, 2'd0, 0);
        // divider: 4 busy cycles, mfhi issues the first idle cycle
        cyc(1, dv,            0, z, 1, 0, 0, 0, 2'd1, 0);
        for (int i = 0; i < 4; i++) cyc(1, mfhi, 0, z, 1, 0, 0, 0, 2'd0, 1);
        cyc(1, mfhi,          0, z, 1, 0, 0, 0, 2'd1, 0);
        // flush with a load pending (r7, r9) and divider busy
        cyc(1, ld7,           0, z, 1, 0, 0, 0, 2'd1, 0);
        cyc(1, dv,            0, z, 1, 0, 0, 0, 2'd1, 0);
        cyc(1, alu(7, 0, 12), 0, z, 1, 0, 0, 1, 2'd0, 1);
        cyc(1, mk(7, 9, 14, 1, 0, 0, 0, 0, 1), 1, alu(9, 0, 15), 1, 0, 0, 0, 2'd2, 0);
        // asynchronous reset mid-BUSY
        cyc(1, dv,            0, z, 1, 0, 0, 0, 2'd1, 0);
        slot0_valid = 1'b0;
        #1;
        check("busy_before_rst", {31'd0, div_busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async_busy", {31'd0, div_busy}, 32'd0);
        check("async_dual", perf_dual_cnt, 32'd0);
        check("async_single", perf_single_cnt, 32'd0);
        check("async_stall", perf_stall_cnt, 32'd0);
        exp_dual = 0; exp_single = 0; exp_stall = 0;
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        cyc(1, mfhi,          0, z, 1, 0, 0, 0, 2'd1, 0);
        cyc(1, alu(1, 2, 3),  1, alu(4, 5, 6), 1, 0, 0, 0, 2'd2, 0);
        slot0_valid = 1'b0;
        slot1_valid = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miss++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
